// File: rtl/noc_flit_ejector.sv
// noc_flit_ejector
//   Terminal ejection stage for a router output port. Credit-flow-controlled
//   flits are buffered in a first-word-fall-through FIFO and presented as an
//   AXI-Stream master. One credit is returned for every flit popped.
//   Packet framing (dest stable within a packet) and overflow are flagged
//   in sticky error bits.
//
// Ports
//   clk_noc, rst_noc     clock / async active-high reset
//   data_in, dest_in,    incoming flit; dest layout is {tid, tdest}
//   is_tail_in, send_in
//   credit_out           registered one-cycle pulse per popped flit
//   axis_out_*           AXI-Stream master (tdata = flit payload)
//   err_clear            synchronous clear of sticky flags (and stats)
//   overflow_err         flit arrived with no free slot and no pop
//   framing_err          dest changed inside a packet
//
// Optional: define NOC_FLIT_EJECTOR_STATS_EN to add flit_count / pkt_count
// pop counters (32-bit, wrapping, cleared by err_clear).
module noc_flit_ejector #(
  parameter int FLIT_WIDTH        = 128,
  parameter int TID_WIDTH         = 2,
  parameter int TDEST_WIDTH       = 4,
  parameter int DEST_WIDTH        = TID_WIDTH + TDEST_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = 8
) (
  input  logic                   clk_noc,
  input  logic                   rst_noc,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [FLIT_WIDTH-1:0]  axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest,
  input  logic                   err_clear,
  output logic                   overflow_err,
  output logic                   framing_err
`ifdef NOC_FLIT_EJECTOR_STATS_EN
  ,
  output logic [31:0]            flit_count,
  output logic [31:0]            pkt_count
`endif
);

  localparam int PTR_W = $clog2(FLIT_BUFFER_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FLIT_BUFFER_DEPTH);

  typedef enum logic { HEAD = 1'b0, BODY = 1'b1 } state_t;

  // Entry layout: {data, dest, tail}
  logic [ENT_W-1:0]      mem_q [FLIT_BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  credit_q, credit_d;
  logic                  ovf_q, ovf_d;
  logic                  frm_q, frm_d;
  state_t                state_q, state_d;
  logic [DEST_WIDTH-1:0] pkt_dest_q, pkt_dest_d;

  logic                  full, pop, push, ovf_evt, frm_evt;
  logic [ENT_W-1:0]      head;

  // ---------------------------------------------------------------- FIFO
  always_comb begin
    full    = (count_q == DEPTH_C);
    pop     = (count_q != '0) & axis_out_tready;
    // When full, a slot frees this same cycle only if the head is popped.
    push    = send_in & (~full | pop);
    ovf_evt = send_in & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    credit_d = pop;
  end

  // Storage has no reset; contents are only observed while count != 0.
  always_ff @(posedge clk_noc) begin
    if (push) mem_q[wr_ptr_q] <= {data_in, dest_in, is_tail_in};
  end

  // ------------------------------------------------------ framing FSM
  // Advances on every send, including dropped flits, so the packet
  // boundary tracking stays aligned with the upstream sender.
  always_comb begin
    state_d    = state_q;
    pkt_dest_d = pkt_dest_q;
    frm_evt    = 1'b0;
    if (send_in) begin
      case (state_q)
        HEAD: begin
          pkt_dest_d = dest_in;
          if (!is_tail_in) state_d = BODY;
        end
        BODY: begin
          if (dest_in != pkt_dest_q) frm_evt = 1'b1;
          if (is_tail_in) state_d = HEAD;
        end
        default: state_d = HEAD;
      endcase
    end
  end

  // A new error in the clear cycle wins over the clear.
  always_comb begin
    ovf_d = (ovf_q & ~err_clear) | ovf_evt;
    frm_d = (frm_q & ~err_clear) | frm_evt;
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      ovf_q      <= 1'b0;
      frm_q      <= 1'b0;
      state_q    <= HEAD;
      pkt_dest_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      ovf_q      <= ovf_d;
      frm_q      <= frm_d;
      state_q    <= state_d;
      pkt_dest_q <= pkt_dest_d;
    end
  end

  // ------------------------------------------------------------ outputs
  assign head            = mem_q[rd_ptr_q];
  assign axis_out_tvalid = (count_q != '0);
  assign axis_out_tdata  = head[ENT_W-1 -: FLIT_WIDTH];
  assign axis_out_tid    = head[DEST_WIDTH -: TID_WIDTH];
  assign axis_out_tdest  = head[TDEST_WIDTH:1];
  assign axis_out_tlast  = head[0];
  assign credit_out      = credit_q;
  assign overflow_err    = ovf_q;
  assign framing_err     = frm_q;

`ifdef NOC_FLIT_EJECTOR_STATS_EN
  logic [31:0] flit_cnt_q, flit_cnt_d;
  logic [31:0] pkt_cnt_q,  pkt_cnt_d;

  always_comb begin
    flit_cnt_d = flit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (err_clear) begin
      flit_cnt_d = '0;
      pkt_cnt_d  = '0;
    end else if (pop) begin
      flit_cnt_d = flit_cnt_q + 32'd1;
      if (axis_out_tlast) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign flit_count = flit_cnt_q;
  assign pkt_count  = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_noc_flit_ejector.sv
module tb_noc_flit_ejector;

  logic         clk_noc = 1'b0;
  logic         rst_noc;
  logic [127:0] data_in;
  logic [5:0]   dest_in;
  logic         is_tail_in, send_in;
  logic         credit_out;
  logic         axis_out_tvalid, axis_out_tready;
  logic [127:0] axis_out_tdata;
  logic         axis_out_tlast;
  logic [1:0]   axis_out_tid;
  logic [3:0]   axis_out_tdest;
  logic         err_clear, overflow_err, framing_err;
`ifdef NOC_FLIT_EJECTOR_STATS_EN
  logic [31:0]  flit_count, pkt_count;
`endif

  noc_flit_ejector dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tlast(axis_out_tlast),
    .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
    .err_clear(err_clear), .overflow_err(overflow_err), .framing_err(framing_err)
`ifdef NOC_FLIT_EJECTOR_STATS_EN
    , .flit_count(flit_count), .pkt_count(pkt_count)
`endif
  );

  always #5 clk_noc = ~clk_noc;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic drive(input logic s, input logic [127:0] d, input logic [5:0] de,
                       input logic t, input logic r, input logic c);
    send_in = s; data_in = d; dest_in = de; is_tail_in = t;
    axis_out_tready = r; err_clear = c;
  endtask

  // Row: inputs applied during the cycle, outputs expected during that same
  // cycle (i.e. the result of earlier cycles). edest = expected {tid,tdest}.
  typedef struct {
    logic         send;
    logic [127:0] data;
    logic [5:0]   dest;
    logic         tail, rdy, clr;
    logic         vld;
    logic [127:0] tdata;
    logic [5:0]   edest;
    logic         tlast, crd, ovf, frm;
  } vec_t;

  function automatic vec_t mk(logic s, logic [127:0] d, logic [5:0] de, logic t, logic r,
                              logic c, logic v, logic [127:0] td, logic [5:0] ed,
                              logic tl, logic cr, logic ov, logic fr);
    vec_t x;
    x.send = s; x.data = d; x.dest = de; x.tail = t; x.rdy = r; x.clr = c;
    x.vld = v; x.tdata = td; x.edest = ed; x.tlast = tl; x.crd = cr; x.ovf = ov; x.frm = fr;
    return x;
  endfunction

  vec_t vecs [17];

  initial begin
    //             send data  dest   tl rd cl | vld tdata edest  tl cr ov fr
    vecs[0]  = mk(1, 'hA5, 6'h23, 1, 0, 0,   0, 0,    6'h00, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0,    0,     0, 1, 0,   1, 'hA5, 6'h23, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0,    0,     0, 1, 0,   0, 0,    6'h00, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0,    0,     0, 0, 0,   0, 0,    6'h00, 0, 0, 0, 0);
    // 3-flit packet with dest 5,5,7
    vecs[4]  = mk(1, 'h11, 6'h05, 0, 0, 0,   0, 0,    6'h00, 0, 0, 0, 0);
    vecs[5]  = mk(1, 'h22, 6'h05, 0, 0, 0,   1, 'h11, 6'h05, 0, 0, 0, 0);
    vecs[6]  = mk(1, 'h33, 6'h07, 1, 0, 0,   1, 'h11, 6'h05, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0,    0,     0, 1, 0,   1, 'h11, 6'h05, 0, 0, 0, 1);
    vecs[8]  = mk(0, 0,    0,     0, 1, 0,   1, 'h22, 6'h05, 0, 1, 0, 1);
    vecs[9]  = mk(0, 0,    0,     0, 1, 0,   1, 'h33, 6'h07, 1, 1, 0, 1);
    vecs[10] = mk(0, 0,    0,     0, 1, 1,   0, 0,    6'h00, 0, 1, 0, 1);
    vecs[11] = mk(0, 0,    0,     0, 1, 0,   0, 0,    6'h00, 0, 0, 0, 0);
    // push into empty FIFO with tready=1: no bypass; then push+pop at count 1
    vecs[12] = mk(1, 'h44, 6'h01, 1, 1, 0,   0, 0,    6'h00, 0, 0, 0, 0);
    vecs[13] = mk(1, 'h55, 6'h01, 1, 1, 0,   1, 'h44, 6'h01, 1, 0, 0, 0);
    vecs[14] = mk(0, 0,    0,     0, 1, 0,   1, 'h55, 6'h01, 1, 1, 0, 0);
    vecs[15] = mk(0, 0,    0,     0, 1, 0,   0, 0,    6'h00, 0, 1, 0, 0);
    vecs[16] = mk(0, 0,    0,     0, 0, 0,   0, 0,    6'h00, 0, 0, 0, 0);

    rst_noc = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_tvalid", 128'(axis_out_tvalid), 0);
    chk("rst_credit", 128'(credit_out), 0);
    chk("rst_ovf",    128'(overflow_err), 0);
    chk("rst_frm",    128'(framing_err), 0);
    step();
    rst_noc = 1'b0;
    step();
    chk("rel_credit", 128'(credit_out), 0);

    // ---------------------------------------------------- table vectors
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("v%0d_tvalid", i), 128'(axis_out_tvalid), 128'(vecs[i].vld));
      chk($sformatf("v%0d_credit", i), 128'(credit_out),      128'(vecs[i].crd));
      chk($sformatf("v%0d_ovf", i),    128'(overflow_err),    128'(vecs[i].ovf));
      chk($sformatf("v%0d_frm", i),    128'(framing_err),     128'(vecs[i].frm));
      if (vecs[i].vld) begin
        chk($sformatf("v%0d_tdata", i), axis_out_tdata,        vecs[i].tdata);
        chk($sformatf("v%0d_tid", i),   128'(axis_out_tid),    128'(vecs[i].edest[5:4]));
        chk($sformatf("v%0d_tdest", i), 128'(axis_out_tdest),  128'(vecs[i].edest[3:0]));
        chk($sformatf("v%0d_tlast", i), 128'(axis_out_tlast),  128'(vecs[i].tlast));
      end
      drive(vecs[i].send, vecs[i].data, vecs[i].dest, vecs[i].tail, vecs[i].rdy, vecs[i].clr);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);

    // ------------------------------------------- backpressure fill to full
    for (int i = 0; i < 8; i++) begin
      chk("fill_credit", 128'(credit_out), 0);
      if (i > 0) begin
        chk("fill_tvalid", 128'(axis_out_tvalid), 1);
        chk("fill_tdata",  axis_out_tdata, 128'h100);
      end
      drive(1, 128'h100 + 128'(i), 6'h09, (i == 7), 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("full_tvalid", 128'(axis_out_tvalid), 1);
    chk("full_ovf",    128'(overflow_err), 0);
    chk("full_credit", 128'(credit_out), 0);

    // overflow: full, no pop -> dropped
    drive(1, 128'h1FF, 6'h09, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("ovf_set",   128'(overflow_err), 1);
    chk("ovf_tdata", axis_out_tdata, 128'h100);
    step();
    chk("ovf_sticky", 128'(overflow_err), 1);
    drive(0, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("ovf_clr", 128'(overflow_err), 0);

    // full with simultaneous pop -> accepted, no error
    drive(1, 128'h200, 6'h09, 1, 1, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    chk("fullpop_ovf",    128'(overflow_err), 0);
    chk("fullpop_credit", 128'(credit_out), 1);
    chk("fullpop_frm",    128'(framing_err), 0);
    for (int j = 0; j < 8; j++) begin
      chk("drain_tvalid", 128'(axis_out_tvalid), 1);
      chk("drain_tdata",  axis_out_tdata, (j < 7) ? 128'h101 + 128'(j) : 128'h200);
      step();
      chk("drain_credit", 128'(credit_out), 1);
    end
    chk("drained_tvalid", 128'(axis_out_tvalid), 0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("drained_credit", 128'(credit_out), 0);

    // ------------------------------------------------- reset mid-packet
    for (int i = 0; i < 4; i++) begin
      drive(1, 128'h300 + 128'(i), 6'h0A, 0, 0, 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("prerst_credit", 128'(credit_out), 1);
    rst_noc = 1'b1;
    #1;
    chk("midrst_tvalid", 128'(axis_out_tvalid), 0);
    chk("midrst_credit", 128'(credit_out), 0);
    step();
    step();
    rst_noc = 1'b0;
    chk("postrst_tvalid", 128'(axis_out_tvalid), 0);
    step();
    chk("postrst_credit", 128'(credit_out), 0);
    chk("postrst_tvalid2", 128'(axis_out_tvalid), 0);
    drive(1, 128'h400, 6'h15, 0, 0, 0);
    step();
    drive(1, 128'h401, 6'h15, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    chk("newhead_frm",   128'(framing_err), 0);
    chk("newhead_tvalid", 128'(axis_out_tvalid), 1);
    chk("newhead_tdata", axis_out_tdata, 128'h400);
    chk("newhead_tid",   128'(axis_out_tid), 1);
    chk("newhead_tdest", 128'(axis_out_tdest), 5);
    drive(0, 0, 0, 0, 1, 0);
    step();
    step();
    step();
    chk("final_tvalid", 128'(axis_out_tvalid), 0);

`ifdef NOC_FLIT_EJECTOR_STATS_EN
    drive(0, 0, 0, 0, 1, 1);
    step();
    chk("stats_clr", 128'(flit_count), 0);
    drive(1, 128'h501, 6'h01, 0, 1, 0); step();
    drive(1, 128'h502, 6'h01, 0, 1, 0); step();
    drive(1, 128'h503, 6'h01, 1, 1, 0); step();
    drive(1, 128'h504, 6'h02, 1, 1, 0); step();
    drive(0, 0, 0, 0, 1, 0);
    step(); step(); step();
    chk("stats_flit", 128'(flit_count), 4);
    chk("stats_pkt",  128'(pkt_count), 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_flit_ejector.md
Name: noc_flit_ejector

Overview:
- Terminal ejection stage on a router output port. Consumes credit-flow-controlled flits (data/dest/is_tail/send) and returns one credit per flit drained.
- Buffers flits in a local FIFO and presents them as an AXI-Stream master with TDATA_WIDTH equal to FLIT_WIDTH. No deserialization.
- Checks packet framing and flow-control violations.
- Sits between a router output and a user endpoint where SERIALIZATION_FACTOR = CLKCROSS_FACTOR = 1.

Parameters:
- FLIT_WIDTH, 128, flit payload width (also the AXIS tdata width).
- TID_WIDTH, 2, tid field width.
- TDEST_WIDTH, 4, tdest field width.
- DEST_WIDTH, TID_WIDTH+TDEST_WIDTH, flit dest width; layout is {tid, tdest}.
- FLIT_BUFFER_DEPTH, 8, FIFO depth in flits; must be a power of two, ≥2; equals the upstream credit count.

Ports:
- clk_noc  in  1  NoC clock; all logic is on its rising edge.
- rst_noc  in  1  Reset; asynchronous assert, active-high.
- data_in  in  FLIT_WIDTH  flit payload.
- dest_in  in  DEST_WIDTH  flit destination {tid, tdest}.
- is_tail_in  in  1  last flit of packet.
- send_in  in  1  flit valid; one flit per asserted cycle.
- credit_out  out  1  one-cycle pulse per freed FIFO slot.
- axis_out_tvalid  out  1  AXIS valid.
- axis_out_tready  in  1  AXIS ready.
- axis_out_tdata  out  FLIT_WIDTH  payload.
- axis_out_tlast  out  1  copy of is_tail.
- axis_out_tid  out  TID_WIDTH  dest[DEST_WIDTH-1:TDEST_WIDTH].
- axis_out_tdest  out  TDEST_WIDTH  dest[TDEST_WIDTH-1:0].
- err_clear  in  1  synchronous clear of the sticky error flags.
- overflow_err  out  1  sticky: flit arrived with no free slot.
- framing_err  out  1  sticky: dest changed mid-packet.

Behaviour:
- Reset values:
  - credit_out = 0, axis_out_tvalid = 0, overflow_err = 0, framing_err = 0.
  - FIFO empty, framing FSM in HEAD.
  - axis_out_tdata/tid/tdest/tlast are don't-care while tvalid = 0.
- Reset asserted mid-packet discards all buffered flits and does not emit credits for them. The upstream credit counter is reset by the same reset domain.
- Push: send_in = 1 writes {data, dest, is_tail} to the FIFO.
- Pop: axis_out_tvalid & axis_out_tready.
- FIFO is first-word-fall-through with a registered count:
  - A flit pushed in cycle N is visible on the AXIS port (tvalid = 1) in cycle N+1 at the earliest.
  - tvalid = (count != 0).
  - AXIS rule: once tvalid rises, tvalid and the payload hold stable until a pop.
- Credit: credit_out is registered; it pulses 1 in cycle N+1 for each pop in cycle N. Back-to-back pops produce back-to-back pulses. No credit is returned at reset release.
- Full push:
  - Full with a simultaneous pop: push accepted, count unchanged.
  - Full with no pop: flit dropped, overflow_err set.
- Simultaneous push and pop on a non-empty, non-full FIFO: count unchanged; ordering preserved.
- Push into an empty FIFO with tready = 1: the flit still takes one cycle; no combinational bypass.
- Framing FSM (input side, advances only on push):
  - HEAD: latch dest_in as pkt_dest. If is_tail_in = 0, go to BODY; if 1, stay in HEAD (single-flit packet).
  - BODY: if dest_in != pkt_dest, set framing_err; the flit is still buffered and delivered. If is_tail_in = 1, go to HEAD.
  - A dropped (overflow) flit still advances the FSM.
- err_clear clears both sticky flags next cycle. A new error in the same cycle as err_clear wins, so the flag stays set.
- Pointers are log2(FLIT_BUFFER_DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: NOC_FLIT_EJECTOR_STATS_EN.
- With the macro defined, two extra outputs are added:
  - flit_count[31:0]: increments on every pop.
  - pkt_count[31:0]: increments on every pop with tlast = 1.
  - Both reset to 0, wrap modulo 2^32, and are cleared by err_clear.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single-flit packet: send data=0xA5, dest=6'b10_0011, tail=1 in cycle 0 → in cycle 1, tvalid=1, tdata=0xA5, tid=2, tdest=3, tlast=1; pop in cycle 1 → credit_out=1 in cycle 2 only.
- Backpressure fill: tready=0, send 8 flits back-to-back → tvalid held, no credits, overflow_err=0. Then tready=1 for 8 cycles → 8 consecutive credit pulses, data in order.
- Overflow: FIFO full, tready=0, send 1 flit → flit dropped, overflow_err=1; the same send with tready=1 → accepted, no error.
- Framing: 3-flit packet with dest 5,5,7 → framing_err=1 after the third push, all 3 flits delivered. err_clear → flag returns to 0.
- Reset mid-packet: 4 flits buffered, assert rst_noc → tvalid=0 and credit_out=0 immediately. After release, FSM is in HEAD and a new head flit is accepted without framing_err.
- Stats (macro on): two packets of 3 and 1 flits fully drained → flit_count=4, pkt_count=2.
